// File: rtl/fixed_pack_writer.sv
// fixed_pack_writer: rounds/saturates 18.14 vectors into 8.7/4.7/2.10/8.1 words, one per handshake (PACK_ROUNDING_EN selects round-half-up vs floor)
module fixed_pack_writer (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_x,
   input  logic [31:0] in_y,
   input  logic [31:0] in_z,
   input  logic [1:0]  in_fmt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic [1:0]  out_index,
   output logic        out_last,
   output logic        out_sat,
   output logic        sat_sticky
);
   typedef enum logic [1:0] {IDLE, EMIT_X, EMIT_Y, EMIT_Z} state_t;
   state_t state_q, state_d;
   logic [31:0] y_q, y_d, z_q, z_d;
   logic [1:0] fmt_q, fmt_d;
   logic [15:0] data_q, data_d;
   logic sat_q, sat_d, sticky_q, sticky_d;
   logic [16:0] pk_x, pk_y, pk_z;
   function automatic logic [16:0] pack(input logic [31:0] v, input logic [1:0] f);
      logic [3:0] s, w;
      logic signed [32:0] e, t, hi, lo;
      s = (f == 2'd2) ? 4'd4 : (f == 2'd3) ? 4'd13 : 4'd7;
      w = (f == 2'd0) ? 4'd15 : (f == 2'd1) ? 4'd11 : (f == 2'd2) ? 4'd12 : 4'd9;
`ifdef PACK_ROUNDING_EN
      e = $signed({v[31], v}) + (33'sd1 <<< (s - 4'd1));
`else
      e = $signed({v[31], v});
`endif
      t = e >>> s;
      hi = (33'sd1 <<< (w - 4'd1)) - 33'sd1;
      lo = -(33'sd1 <<< (w - 4'd1));
      return (t > hi) ? {1'b1, hi[15:0]} : (t < lo) ? {1'b1, lo[15:0]} : {1'b0, t[15:0]};
   endfunction
   assign pk_x = pack(in_x, in_fmt);
   assign pk_y = pack(y_q, fmt_q);
   assign pk_z = pack(z_q, fmt_q);
   assign in_ready = state_q == IDLE;
   assign out_valid = state_q != IDLE;
   assign out_data = data_q;
   assign out_sat = sat_q;
   assign out_index = (state_q == EMIT_Y) ? 2'd1 : (state_q == EMIT_Z) ? 2'd2 : 2'd0;
   assign out_last = state_q == EMIT_Z;
   assign sat_sticky = sticky_q;
   // next state: X is packed at acceptance, each later word is packed when the previous one is taken
   always_comb begin
      state_d = state_q;
      y_d = y_q;
      z_d = z_q;
      fmt_d = fmt_q;
      data_d = data_q;
      sat_d = sat_q;
      sticky_d = sticky_q;
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = EMIT_X;
            y_d = in_y;
            z_d = in_z;
            fmt_d = in_fmt;
            data_d = pk_x[15:0];
            sat_d = pk_x[16];
            sticky_d = 1'b0;
         end
         EMIT_X: if (out_ready) begin
            state_d = EMIT_Y;
            data_d = pk_y[15:0];
            sat_d = pk_y[16];
            sticky_d = sticky_q | sat_q;
         end
         EMIT_Y: if (out_ready) begin
            state_d = EMIT_Z;
            data_d = pk_z[15:0];
            sat_d = pk_z[16];
            sticky_d = sticky_q | sat_q;
         end
         default: if (out_ready) begin
            state_d = IDLE;
            sticky_d = sticky_q | sat_q;
         end
      endcase
   end
   // state and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         y_q <= '0;
         z_q <= '0;
         fmt_q <= '0;
         data_q <= '0;
         sat_q <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q <= y_d;
         z_q <= z_d;
         fmt_q <= fmt_d;
         data_q <= data_d;
         sat_q <= sat_d;
         sticky_q <= sticky_d;
      end
   end
endmodule

// File: tb/tb_fixed_pack_writer.sv
// tb_fixed_pack_writer: randomized and directed checks of fixed_pack_writer against an arithmetic model
module tb_fixed_pack_writer;
   logic clock = 0, reset = 1, in_valid = 0, out_ready = 0;
   logic [31:0] in_x = 0, in_y = 0, in_z = 0;
   logic [1:0] in_fmt = 0;
   logic in_ready, out_valid, out_last, out_sat, sat_sticky;
   logic [15:0] out_data;
   logic [1:0] out_index;
   int tests = 0, fails = 0, cyc = 0;
   int acc_cyc, got_n;
   logic [15:0] got_data [3];
   logic got_sat [3], got_last [3], got_stk_before [3], got_stk_after [3];
   logic [1:0] got_idx [3];
   int got_cyc [3];

   fixed_pack_writer dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_fmt(in_fmt),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_last(out_last), .out_sat(out_sat), .sat_sticky(sat_sticky)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // value / 2^s with floor division, optional half-up bias, then clamp to W bits
   function automatic logic [16:0] model(input logic [31:0] v, input logic [1:0] f);
      longint a, d, q, hi;
      int s, w;
      logic sat;
      s = (f == 2) ? 4 : (f == 3) ? 13 : 7;
      w = (f == 0) ? 15 : (f == 1) ? 11 : (f == 2) ? 12 : 9;
      d = 1;
      for (int i = 0; i < s; i++) d = d * 2;
      hi = 1;
      for (int i = 0; i < w - 1; i++) hi = hi * 2;
      a = longint'($signed(v));
`ifdef PACK_ROUNDING_EN
      a = a + d / 2;
`endif
      q = a / d;
      if (a % d != 0 && a < 0) q = q - 1;
      sat = 0;
      if (q > hi - 1) begin q = hi - 1; sat = 1; end
      else if (q < -hi) begin q = -hi; sat = 1; end
      return {sat, q[15:0]};
   endfunction

   function automatic logic [31:0] rnd_val();
      logic [31:0] m;
      m = $urandom >> $urandom_range(31, 8);
      return $urandom_range(1) ? -m : m;
   endfunction

   // drive one vector and capture the three words; pct = out_ready probability in percent
   task automatic run_vec(input logic [31:0] x, y, z, input logic [1:0] f, input int pct);
      int budget;
      logic hs;
      budget = 0;
      got_n = 0;
      while (!in_ready && budget < 50) begin @(negedge clock); budget++; end
      in_x = x; in_y = y; in_z = z; in_fmt = f; in_valid = 1;
      @(negedge clock);
      in_valid = 0;
      acc_cyc = cyc;
      budget = 0;
      while (got_n < 3 && budget < 300) begin
         out_ready = ($urandom_range(99) < pct);
         hs = out_valid && out_ready;
         if (hs) begin
            got_data[got_n] = out_data; got_sat[got_n] = out_sat; got_idx[got_n] = out_index;
            got_last[got_n] = out_last; got_stk_before[got_n] = sat_sticky; got_cyc[got_n] = cyc;
         end
         @(negedge clock);
         budget++;
         if (hs) begin got_stk_after[got_n] = sat_sticky; got_n++; end
      end
      out_ready = 0;
   endtask

   task automatic test_reset();
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
      tests++; if (out_data !== 16'h0) begin fails++; $display("FAIL reset_out_data: got %h exp 0000", out_data); end
      tests++; if (out_index !== 2'd0) begin fails++; $display("FAIL reset_out_index: got %0d exp 0", out_index); end
      tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last: got %b exp 0", out_last); end
      tests++; if (out_sat !== 1'b0) begin fails++; $display("FAIL reset_out_sat: got %b exp 0", out_sat); end
      tests++; if (sat_sticky !== 1'b0) begin fails++; $display("FAIL reset_sticky: got %b exp 0", sat_sticky); end
   endtask

   task automatic test_encode_87();
      logic [15:0] exp [3];
      exp[0] = 16'h0080; exp[1] = 16'hFF80; exp[2] = 16'h0000;
      run_vec(32'h00004000, 32'hFFFFC000, 32'h0, 2'd0, 100);
      tests++; if (got_n !== 3) begin fails++; $display("FAIL enc87_words: got %0d exp 3", got_n); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL enc87_in_ready_after: got %b exp 1", in_ready); end
      for (int k = 0; k < got_n; k++) begin
         tests++; if (got_data[k] !== exp[k]) begin fails++; $display("FAIL enc87_data%0d: got %h exp %h", k, got_data[k], exp[k]); end
         tests++; if (got_last[k] !== (k == 2)) begin fails++; $display("FAIL enc87_last%0d: got %b exp %b", k, got_last[k], k == 2); end
         tests++; if (got_idx[k] !== 2'(k)) begin fails++; $display("FAIL enc87_index%0d: got %0d exp %0d", k, got_idx[k], k); end
         tests++; if (got_cyc[k] !== acc_cyc + k) begin fails++; $display("FAIL enc87_timing%0d: got %0d exp %0d", k, got_cyc[k], acc_cyc + k); end
      end
   endtask

   task automatic test_saturation();
      logic [15:0] exp_d [3];
      logic exp_s [3];
      exp_d[0] = 16'h07FF; exp_d[1] = 16'hF800; exp_d[2] = 16'h0100;
      exp_s[0] = 1; exp_s[1] = 1; exp_s[2] = 0;
      run_vec(32'h00008000, 32'hFFFF0000, 32'h00001000, 2'd2, 100);
      tests++; if (got_n !== 3) begin fails++; $display("FAIL sat_words: got %0d exp 3", got_n); end
      for (int k = 0; k < got_n; k++) begin
         tests++; if (got_data[k] !== exp_d[k]) begin fails++; $display("FAIL sat_data%0d: got %h exp %h", k, got_data[k], exp_d[k]); end
         tests++; if (got_sat[k] !== exp_s[k]) begin fails++; $display("FAIL sat_flag%0d: got %b exp %b", k, got_sat[k], exp_s[k]); end
      end
      tests++; if (got_stk_after[0] !== 1'b1) begin fails++; $display("FAIL sat_sticky_after_x: got %b exp 1", got_stk_after[0]); end
      tests++; if (sat_sticky !== 1'b1) begin fails++; $display("FAIL sat_sticky_idle: got %b exp 1", sat_sticky); end
      run_vec(32'h00001000, 32'h0, 32'h0, 2'd2, 100);
      tests++; if (got_stk_before[0] !== 1'b0) begin fails++; $display("FAIL sat_sticky_cleared: got %b exp 0", got_stk_before[0]); end
   endtask

   task automatic test_rounding();
      logic [15:0] e0, e1;
`ifdef PACK_ROUNDING_EN
      e0 = 16'h0001; e1 = 16'h0000;
`else
      e0 = 16'h0000; e1 = 16'hFFFF;
`endif
      run_vec(32'h00000040, 32'hFFFFFFC0, 32'h0, 2'd0, 100);
      tests++; if (got_data[0] !== e0) begin fails++; $display("FAIL round_x: got %h exp %h", got_data[0], e0); end
      tests++; if (got_data[1] !== e1) begin fails++; $display("FAIL round_y: got %h exp %h", got_data[1], e1); end
   endtask

   task automatic test_fmt_81_47();
      run_vec(32'h00006000, 32'h0, 32'h0, 2'd3, 100);
      tests++; if (got_data[0] !== 16'h0003) begin fails++; $display("FAIL fmt81_x: got %h exp 0003", got_data[0]); end
      run_vec(32'h00200000, 32'h0, 32'h0, 2'd1, 100);
      tests++; if (got_data[0] !== 16'h03FF) begin fails++; $display("FAIL fmt47_x: got %h exp 03ff", got_data[0]); end
      tests++; if (got_sat[0] !== 1'b1) begin fails++; $display("FAIL fmt47_sat: got %b exp 1", got_sat[0]); end
   endtask

   task automatic test_random();
      logic [31:0] v [3];
      logic [1:0] f;
      logic [16:0] m;
      for (int n = 0; n < 40; n++) begin
         for (int k = 0; k < 3; k++) v[k] = rnd_val();
         f = 2'($urandom_range(3));
         run_vec(v[0], v[1], v[2], f, 60);
         tests++; if (got_n !== 3) begin fails++; $display("FAIL rand_words: got %0d exp 3", got_n); end
         for (int k = 0; k < got_n; k++) begin
            m = model(v[k], f);
            tests++; if (got_data[k] !== m[15:0]) begin fails++; $display("FAIL rand_data v=%h fmt=%0d: got %h exp %h", v[k], f, got_data[k], m[15:0]); end
            tests++; if (got_sat[k] !== m[16]) begin fails++; $display("FAIL rand_sat v=%h fmt=%0d: got %b exp %b", v[k], f, got_sat[k], m[16]); end
            tests++; if (got_idx[k] !== 2'(k)) begin fails++; $display("FAIL rand_index: got %0d exp %0d", got_idx[k], k); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] y, z;
      logic [16:0] my, mz;
      y = rnd_val(); z = rnd_val();
      my = model(y, 2'd0); mz = model(z, 2'd0);
      in_x = rnd_val(); in_y = y; in_z = z; in_fmt = 0; in_valid = 1;
      @(negedge clock);
      in_valid = 0; out_ready = 1;
      @(negedge clock);
      out_ready = 0;
      for (int c = 0; c < 5; c++) begin
         tests++; if (out_data !== my[15:0] || out_index !== 2'd1 || out_valid !== 1'b1) begin
            fails++; $display("FAIL bp_hold%0d: got %h/%0d/%b exp %h/1/1", c, out_data, out_index, out_valid, my[15:0]);
         end
         tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready%0d: got %b exp 0", c, in_ready); end
         in_x = $urandom; in_y = $urandom; in_z = $urandom; in_fmt = 2'($urandom_range(3)); in_valid = 1'($urandom_range(1));
         @(negedge clock);
      end
      in_valid = 0; out_ready = 1;
      @(negedge clock);
      tests++; if (out_data !== mz[15:0] || out_index !== 2'd2 || out_last !== 1'b1) begin
         fails++; $display("FAIL bp_z: got %h/%0d/%b exp %h/2/1", out_data, out_index, out_last, mz[15:0]);
      end
      @(negedge clock);
      out_ready = 0;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_idle: got %b exp 1", in_ready); end
   endtask

   task automatic test_reset_mid();
      logic [16:0] m;
      in_x = 32'h7FFFFFFF; in_y = 32'h1234; in_z = 32'h5678; in_fmt = 0; in_valid = 1;
      @(negedge clock);
      in_valid = 0; out_ready = 1;
      @(negedge clock);
      out_ready = 0;
      tests++; if (sat_sticky !== 1'b1 || out_index !== 2'd1) begin fails++; $display("FAIL rst_pre: got %b/%0d exp 1/1", sat_sticky, out_index); end
      reset = 1;
      @(negedge clock);
      reset = 0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
      tests++; if (sat_sticky !== 1'b0) begin fails++; $display("FAIL rst_sticky: got %b exp 0", sat_sticky); end
      run_vec(32'h00002000, 32'h0, 32'h0, 2'd0, 100);
      m = model(32'h00002000, 2'd0);
      tests++; if (got_idx[0] !== 2'd0 || got_data[0] !== m[15:0]) begin fails++; $display("FAIL rst_next_x: got %0d/%h exp 0/%h", got_idx[0], got_data[0], m[15:0]); end
   endtask

   task automatic test_back_to_back();
      int first;
      run_vec(32'h100, 32'h200, 32'h300, 2'd2, 100);
      first = acc_cyc;
      run_vec(32'h400, 32'h500, 32'h600, 2'd2, 100);
      tests++; if (acc_cyc - first !== 4) begin fails++; $display("FAIL b2b_rate: got %0d exp 4", acc_cyc - first); end
      tests++; if (got_data[2] !== 16'h0060) begin fails++; $display("FAIL b2b_z: got %h exp 0060", got_data[2]); end
   endtask

   initial begin
      repeat (2) @(negedge clock);
      reset = 0;
      test_reset();
      test_encode_87();
      test_saturation();
      test_rounding();
      test_fmt_81_47();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fixed_pack_writer.md
# fixed_pack_writer

Converts 3-component vectors from internal 18.14 signed fixed point into the packed narrow formats used by host-visible registers and the command buffer (8.7, 4.7, 2.10, 8.1). It rounds, saturates and serialises one 16-bit word per component over a valid/ready stream. It sits between the ray-tracing core's result registers and the host-side write port, and is the outbound counterpart of the format-to-fixed conversions in the maths package.

## Interface

- No parameters; all widths are fixed by the 18.14 internal format (14 fractional bits).
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  vector request present.
- in_ready  out  1  block idle and able to accept a request.
- in_x, in_y, in_z  in  32 each  signed 18.14 components.
- in_fmt  in  2  target format: 0 = 8.7 (15b), 1 = 4.7 (11b), 2 = 2.10 (12b), 3 = 8.1 (9b).
- out_valid  out  1  packed word present.
- out_ready  in  1  consumer accepts word.
- out_data  out  16  packed value, sign-extended to 16 bits.
- out_index  out  2  component index: 0 = X, 1 = Y, 2 = Z.
- out_last  out  1  high with the Z word.
- out_sat  out  1  this word was clamped.
- sat_sticky  out  1  set by any clamped word; cleared only by reset or by accepting a new request.

## Operation

- FSM states: IDLE, EMIT_X, EMIT_Y, EMIT_Z.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch x, y, z and fmt, clear sat_sticky, go to EMIT_X.
- EMIT_n:
  - out_valid = 1.
  - out_data, out_sat, out_index and out_last are driven from registers computed for component n.
  - On out_valid & out_ready, advance EMIT_X → EMIT_Y → EMIT_Z → IDLE.
  - Otherwise hold; all out_* stay stable while out_ready is low.
- Conversion per component (33-bit signed intermediate, no overflow):
  - Shift s is 7 for fmt 0/1, 4 for fmt 2, 13 for fmt 3.
  - t = (v + 2^(s-1)) >>> s, arithmetic shift.
  - Clamp t to [-2^(W-1), 2^(W-1)-1], where W is the format width.
  - out_sat = 1 when a clamp occurs; sat_sticky |= out_sat on the handshake.
  - Result is sign-extended to 16 bits.
- Latched inputs are not re-sampled after acceptance; in_* changes during EMIT states have no effect.
- in_valid while busy is ignored (in_ready = 0); no request queueing.
- Reset in any state:
  - Returns to IDLE.
  - Drops any in-flight vector; no partial words are emitted afterwards.

## Timing

- Reset values:
  - in_ready = 1.
  - out_valid = 0, out_data = 0, out_index = 0, out_last = 0, out_sat = 0, sat_sticky = 0.
- Latency: out_valid for X rises the cycle after the input handshake.
- Throughput: each subsequent word is available the cycle after the previous handshake. With out_ready held high, X, Y and Z occupy 3 consecutive cycles.
- in_ready rises the cycle after the Z handshake.
- Peak rate: one vector per 4 cycles.
- out_last = 1 only when out_index = 2.
- Outputs are registered; there is no combinational path from in_* or out_ready to out_data.

## Configuration

- PACK_ROUNDING_EN defined: round-half-up as specified (add 2^(s-1) before the shift).
- PACK_ROUNDING_EN undefined: truncate toward negative infinity (plain arithmetic shift, no bias add); saturation is unchanged.
- Timing is identical in both builds.

## Test plan

- 8.7 encode: fmt=0, x=0x00004000, y=0xFFFFC000, z=0 with out_ready high.
  - Required: 0x0080, 0xFF80, 0x0000 on consecutive cycles.
  - out_last only on the third word; in_ready high the next cycle.
- Saturation: fmt=2, x=0x00008000 (2.0), y=0xFFFF0000 (-4.0), z=0x00001000.
  - Required: 0x07FF (sat=1), 0xF800 (sat=1), 0x0100 (sat=0).
  - sat_sticky = 1 after X and cleared on the next accepted request.
- Rounding: fmt=0, x=0x00000040, y=0xFFFFFFC0.
  - With PACK_ROUNDING_EN: 0x0001, 0x0000.
  - Without: 0x0000, 0xFFFF.
- 8.1 and 4.7 encode:
  - fmt=3, x=0x00006000: required 0x0003.
  - fmt=1, x=0x00200000: required 0x03FF with sat=1.
- Backpressure: hold out_ready low 5 cycles during EMIT_Y while toggling in_* and in_valid.
  - out_data and out_index stay constant; in_ready stays 0; latched vector is unaffected.
- Reset mid-operation: assert reset for 1 cycle in EMIT_Y.
  - Next cycle: out_valid = 0, in_ready = 1, sat_sticky = 0.
  - A following request emits its X word first.
